cmd_master: RTL
===============

// Module: cmd_master
// PURPOSE
//  SD host command-layer controller; sits directly upstream of the command PHY.
//  Turns a host request (index + argument) into a 40-bit command token and drives
//  the PHY strobe/ack handshake. Captures and validates the 40-bit response, and
//  enforces a response timeout. Reports the result to the host register interface.
// PARAMETERS
//  TIMEOUT_CYCLES  512  sd_clock cycles allowed from strobe pulse to PHY response (also bounds ack wait)
//  CNT_W           10   width of timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  sd_clock         in   1   clock; all logic on rising edge
//  reset            in   1   asynchronous, active-high reset
//  new_command      in   1   host request pulse; accepted only when busy=0
//  cmd_index        in   6   command index, sampled with new_command
//  cmd_argument     in   32  command argument, sampled with new_command
//  check_index      in   1   1: response index must equal cmd_index (off for R2/R3)
//  abort            in   1   host abort; forces PHY and block back to idle
//  busy             out  1   high from accept until cmd_done
//  cmd_done         out  1   1-cycle pulse, transaction finished (ok or error)
//  response_arg     out  32  response payload bits [31:0], held until next accept
//  response_index   out  6   response bits [37:32], held until next accept
//  timeout_error    out  1   valid with cmd_done; held until next accept
//  index_error      out  1   valid with cmd_done; held until next accept
//  frame_error      out  1   start/direction bits wrong; held until next accept
//  cmd_to_send      out  40  to PHY: {1'b0,1'b1,index[5:0],arg[31:0]}, held stable while busy
//  strobe_out       out  1   to PHY strobe_in; exactly one-cycle pulse per command
//  ack_out          out  1   to PHY ack_in; response-received acknowledge
//  idle_out         out  1   to PHY idle_in; one-cycle pulse forcing PHY to IDLE
//  strobe_in        in   1   from PHY strobe_out; 1-cycle pulse, response valid
//  ack_in           in   1   from PHY ack_out; PHY saw our ack
//  response         in   40  from PHY; sampled only when strobe_in=1
// BEHAVIOUR
//  Reset: every output 0; state IDLE; counter 0. Reset mid-transaction aborts silently.
//    No idle_out and no cmd_done are issued.
//  All outputs registered. FSM states: IDLE, STROBE, WAIT_RESP, CHECK, ACK, ABORT, DONE.
//  IDLE: new_command=1 -> latch index/arg into cmd_to_send, clear error flags, busy=1 -> STROBE.
//  STROBE: strobe_out=1 for this single cycle (cycle N+1 after accept), counter cleared -> WAIT_RESP.
//  WAIT_RESP: counter increments each cycle.
//    strobe_in=1 -> capture response -> CHECK.
//    Else if counter==TIMEOUT_CYCLES-1 -> timeout_error=1 -> ABORT.
//    strobe_in and expiry in the same cycle: response wins.
//  CHECK (1 cycle): frame_error = response[39]!=0 | response[38]!=0.
//    index_error = check_index & (response[37:32]!=cmd_index).
//    Load response_arg/response_index. Then -> ACK.
//  ACK: ack_out=1, counter cleared on entry.
//    ack_in=1 -> ack_out drops next cycle -> DONE.
//    No ack_in within TIMEOUT_CYCLES -> timeout_error=1 -> ABORT.
//  ABORT: idle_out=1 for exactly one cycle -> DONE.
//  DONE: cmd_done=1 for one cycle, busy=0 on the following cycle -> IDLE.
//  abort=1 in STROBE/WAIT_RESP/CHECK/ACK -> ABORT next cycle.
//    No error flag is set by abort. abort in IDLE/ABORT/DONE is ignored.
//  new_command while busy=1 is ignored (not queued).
//  A strobe_in arriving outside WAIT_RESP is ignored.
//  strobe_out and idle_out are never high in the same cycle.
//  Error flags are not mutually exclusive (frame and index may both set).
//  Minimum latency accept->cmd_done with immediate PHY response and ack: 6 cycles.
// TESTING
//  1. new_command idx=17 arg=32'h0000_0200 -> cmd_to_send=40'h51_0000_0200 and strobe_out
//     1 cycle. PHY model returns 40'h11_0000_0900 with ack -> cmd_done, arg 32'h900, all
//     error flags 0.
//  2. PHY model never answers -> strobe_in absent 512 cycles -> idle_out pulse,
//     cmd_done with timeout_error=1, busy low after.
//  3. Response 40'h12_0000_0000 to idx=17 with check_index=1 -> index_error=1.
//     Same with check_index=0 -> index_error=0. Response 40'h51_... -> frame_error=1.
//  4. abort asserted 20 cycles into WAIT_RESP -> idle_out next cycle, cmd_done, all error
//     flags 0. A late strobe_in afterwards is ignored.
//  5. new_command pulsed again while busy -> ignored, cmd_to_send unchanged, single strobe_out.
//     strobe_in on the same cycle as timeout expiry -> no timeout_error.
//  6. reset asserted asynchronously during ACK -> all outputs 0 immediately.
//     A fresh command afterwards completes normally.

Source files
------------

// File: rtl/cmd_master_if.sv
// Link between the SD command-layer controller (master) and the command PHY (slave).
interface cmd_master_if;
  logic [39:0] cmd_to_send;
  logic        strobe_out;
  logic        ack_out;
  logic        idle_out;
  logic        strobe_in;
  logic        ack_in;
  logic [39:0] response;

  modport master (
    output cmd_to_send,
    output strobe_out,
    output ack_out,
    output idle_out,
    input  strobe_in,
    input  ack_in,
    input  response
  );

  modport slave (
    input  cmd_to_send,
    input  strobe_out,
    input  ack_out,
    input  idle_out,
    output strobe_in,
    output ack_in,
    output response
  );
endinterface

// File: rtl/cmd_master.sv
// SD host command-layer controller: builds the 40-bit command token, runs the PHY
// strobe/ack handshake, validates the response and enforces response/ack timeouts.
module cmd_master #(
  parameter int TIMEOUT_CYCLES = 512,
  parameter int CNT_W          = 10
) (
  input  logic                sd_clock,
  input  logic                reset,
  input  logic                new_command,
  input  logic [5:0]          cmd_index,
  input  logic [31:0]         cmd_argument,
  input  logic                check_index,
  input  logic                abort,
  output logic                busy,
  output logic                cmd_done,
  output logic [31:0]         response_arg,
  output logic [5:0]          response_index,
  output logic                timeout_error,
  output logic                index_error,
  output logic                frame_error,
  cmd_master_if.master        phy
);

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT_RESP,
    CHECK,
    ACK,
    ABORT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [39:0] resp_cap_q, resp_cap_d;
  logic [39:0] cmd_q, cmd_d;
  logic [31:0] rarg_q, rarg_d;
  logic [5:0]  ridx_q, ridx_d;
  logic        terr_q, terr_d;
  logic        ierr_q, ierr_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        strobe_q, strobe_d;
  logic        ack_q, ack_d;
  logic        idle_q, idle_d;

  // One counter serves both the response wait and the ack wait; it is cleared
  // on entry to each, so both get the same budget of TIMEOUT_CYCLES cycles.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    resp_cap_d = resp_cap_q;
    cmd_d      = cmd_q;
    rarg_d     = rarg_q;
    ridx_d     = ridx_q;
    terr_d     = terr_q;
    ierr_d     = ierr_q;
    ferr_d     = ferr_q;

    unique case (state_q)
      IDLE: begin
        if (new_command) begin
          cmd_d   = {1'b0, 1'b1, cmd_index, cmd_argument};
          terr_d  = 1'b0;
          ierr_d  = 1'b0;
          ferr_d  = 1'b0;
          rarg_d  = '0;
          ridx_d  = '0;
          state_d = STROBE;
        end
      end

      STROBE: begin
        cnt_d   = '0;
        state_d = abort ? ABORT : WAIT_RESP;
      end

      // A response arriving in the expiry cycle still counts as on time.
      WAIT_RESP: begin
        if (abort) begin
          state_d = ABORT;
        end else if (phy.strobe_in) begin
          resp_cap_d = phy.response;
          state_d    = CHECK;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      CHECK: begin
        if (abort) begin
          state_d = ABORT;
        end else begin
          ferr_d  = resp_cap_q[39] | resp_cap_q[38];
          ierr_d  = check_index & (resp_cap_q[37:32] != cmd_q[37:32]);
          rarg_d  = resp_cap_q[31:0];
          ridx_d  = resp_cap_q[37:32];
          cnt_d   = '0;
          state_d = ACK;
        end
      end

      ACK: begin
        if (abort) begin
          state_d = ABORT;
        end else if (phy.ack_in) begin
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          terr_d  = 1'b1;
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ABORT: state_d = DONE;

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the next state, so each is
  // high for exactly the cycles the FSM spends in the matching state.
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    strobe_d = (state_d == STROBE);
    ack_d    = (state_d == ACK);
    idle_d   = (state_d == ABORT);
  end

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      resp_cap_q <= '0;
      cmd_q      <= '0;
      rarg_q     <= '0;
      ridx_q     <= '0;
      terr_q     <= 1'b0;
      ierr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      strobe_q   <= 1'b0;
      ack_q      <= 1'b0;
      idle_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      resp_cap_q <= resp_cap_d;
      cmd_q      <= cmd_d;
      rarg_q     <= rarg_d;
      ridx_q     <= ridx_d;
      terr_q     <= terr_d;
      ierr_q     <= ierr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      strobe_q   <= strobe_d;
      ack_q      <= ack_d;
      idle_q     <= idle_d;
    end
  end

  assign busy            = busy_q;
  assign cmd_done        = done_q;
  assign response_arg    = rarg_q;
  assign response_index  = ridx_q;
  assign timeout_error   = terr_q;
  assign index_error     = ierr_q;
  assign frame_error     = ferr_q;
  assign phy.cmd_to_send = cmd_q;
  assign phy.strobe_out  = strobe_q;
  assign phy.ack_out     = ack_q;
  assign phy.idle_out    = idle_q;

endmodule
